// File: rtl/bus_xbar_rr.sv
// Shared-path bus crossbar: NM masters to NS slaves, round-robin arbitration,
// table-driven decode, one-entry write/read data stages and an error channel.
module bus_xbar_rr #(
    parameter int unsigned      NM         = 2,
    parameter int unsigned      NS         = 4,
    parameter int unsigned      AW         = 27,
    parameter logic [NS*AW-1:0] SLV_BASE   = '0,
    parameter logic [NS*AW-1:0] SLV_MASK   = '0,
    parameter logic [NS-1:0]    SLV_NOLAST = '0
) (
    input  logic              clk_core,
    input  logic              reset_n,
    input  logic [NM-1:0]     m_cvalid_i,
    output logic [NM-1:0]     m_cready_o,
    input  logic [NM-1:0]     m_cmd_i,
    input  logic [NM*AW-1:0]  m_addr_i,
    input  logic [NM-1:0]     m_wvalid_i,
    output logic [NM-1:0]     m_wready_o,
    input  logic [NM-1:0]     m_wlast_i,
    input  logic [NM*32-1:0]  m_wdata_i,
    input  logic [NM*4-1:0]   m_wmask_i,
    output logic [NM-1:0]     m_rvalid_o,
    input  logic [NM-1:0]     m_rready_i,
    output logic              m_rlast_o,
    output logic [31:0]       m_rdata_o,
    output logic [NM-1:0]     m_error_o,
    input  logic [NM-1:0]     m_eack_i,
    output logic              s_cmd_o,
    output logic [AW-1:0]     s_addr_o,
    output logic              s_wlast_o,
    output logic [31:0]       s_wdata_o,
    output logic [3:0]        s_wmask_o,
    output logic [NS-1:0]     s_cvalid_o,
    input  logic [NS-1:0]     s_cready_i,
    output logic [NS-1:0]     s_wvalid_o,
    input  logic [NS-1:0]     s_wready_i,
    input  logic [NS-1:0]     s_rvalid_i,
    output logic [NS-1:0]     s_rready_o,
    input  logic [NS-1:0]     s_rlast_i,
    input  logic [NS*32-1:0]  s_rdata_i,
    input  logic [NS-1:0]     s_error_i,
    output logic [NS-1:0]     s_eack_o
);
    localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, ERR} state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   ptr_q, ptr_d, src_q, src_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            cmd_q, cmd_d, sent_q, sent_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wfull_q, wfull_d, wlast_q, wlast_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   wmask_q, wmask_d;
    logic            rfull_q, rfull_d, rlast_q, rlast_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [MW-1:0]   win, cand;
    logic            any_req, hit;
    logic [AW-1:0]   win_addr;
    logic [SW-1:0]   hit_idx;
    logic            act, serr, act_ok, drain, errs;
    logic            s_wbeat, m_wrdy, m_wbeat, m_rbeat, s_rrdy, s_rbeat;
    logic            eack, done, can_acc, cbeat;

    // Round-robin pick starting at ptr, then decode the winner's address (lowest slave wins)
    always_comb begin
        win     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NM; i++) begin
            cand = MW'((32'(ptr_q) + i) % NM);
            if (!any_req && m_cvalid_i[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
        win_addr = m_addr_i[32'(win)*AW +: AW];
        hit      = 1'b0;
        hit_idx  = '0;
        for (int unsigned k = NS; k > 0; k--) begin
            if ((win_addr & SLV_MASK[(k-1)*AW +: AW]) == SLV_BASE[(k-1)*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = SW'(k - 1);
            end
        end
    end

    // Handshake qualifiers for the transaction in flight; reset blocks all handshakes
    always_comb begin
        act     = reset_n && (state_q == ACTIVE);
        drain   = reset_n && (state_q == DRAIN);
        errs    = reset_n && (state_q == ERR);
        serr    = act && s_error_i[sel_q];
        act_ok  = act && !serr;
        eack    = m_eack_i[src_q];
        s_wbeat = act_ok && wfull_q && s_wready_i[sel_q];
        m_wrdy  = act_ok && !cmd_q && (!wfull_q || (s_wbeat && !wlast_q));
        m_wbeat = m_wrdy && m_wvalid_i[src_q];
        m_rbeat = act_ok && rfull_q && m_rready_i[src_q];
        s_rrdy  = act_ok && cmd_q && (!rfull_q || (m_rbeat && !rlast_q));
        s_rbeat = s_rrdy && s_rvalid_i[sel_q];
        done    = (act_ok && ((m_rbeat && rlast_q) || (s_wbeat && wlast_q)))
                || (serr && eack) || (errs && eack);
        can_acc = reset_n && ((state_q == IDLE) || done);
        cbeat   = can_acc && any_req;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        sel_d   = sel_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        sent_d  = sent_q;
        wfull_d = wfull_q;
        wlast_d = wlast_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rfull_d = rfull_q;
        rlast_d = rlast_q;
        rdata_d = rdata_q;

        m_cready_o = '0;
        m_wready_o = '0;
        m_rvalid_o = '0;
        m_error_o  = '0;
        s_cvalid_o = '0;
        s_wvalid_o = '0;
        s_rready_o = '0;
        s_eack_o   = '0;

        m_cready_o[win]   = cbeat;
        m_wready_o[src_q] = m_wrdy || drain;
        m_rvalid_o[src_q] = act_ok && rfull_q;
        m_error_o[src_q]  = serr || errs;
        s_cvalid_o[sel_q] = act_ok && !sent_q;
        s_wvalid_o[sel_q] = act_ok && wfull_q;
        s_rready_o[sel_q] = s_rrdy;
        s_eack_o[sel_q]   = serr && eack;

        if (act_ok && !sent_q && s_cready_i[sel_q]) begin
            sent_d = 1'b1;
        end

        if (m_wbeat) begin
            wfull_d = 1'b1;
            wdata_d = m_wdata_i[32'(src_q)*DW +: DW];
            wmask_d = m_wmask_i[32'(src_q)*BW +: BW];
            wlast_d = m_wlast_i[src_q];
        end else if (s_wbeat) begin
            wfull_d = 1'b0;
        end

        if (s_rbeat) begin
            rfull_d = 1'b1;
            rdata_d = s_rdata_i[32'(sel_q)*DW +: DW];
            rlast_d = s_rlast_i[sel_q] || SLV_NOLAST[sel_q];
        end else if (m_rbeat) begin
            rfull_d = 1'b0;
        end

        if (serr) begin
            wfull_d = 1'b0;
            rfull_d = 1'b0;
        end

        if (drain && m_wvalid_i[src_q] && m_wlast_i[src_q]) begin
            state_d = ERR;
        end

        if (done) begin
            state_d = IDLE;
            wfull_d = 1'b0;
            rfull_d = 1'b0;
        end

        if (cbeat) begin
            cmd_d  = m_cmd_i[win];
            addr_d = win_addr;
            src_d  = win;
            sel_d  = hit_idx;
            sent_d = 1'b0;
            ptr_d  = (32'(win) == NM - 1) ? '0 : MW'(32'(win) + 1);
            if (hit) begin
                state_d = ACTIVE;
            end else if (m_cmd_i[win]) begin
                state_d = ERR;
            end else begin
                state_d = DRAIN;
            end
        end
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            sel_q   <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            sent_q  <= 1'b0;
            wfull_q <= 1'b0;
            wlast_q <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rfull_q <= 1'b0;
            rlast_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            sel_q   <= sel_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            sent_q  <= sent_d;
            wfull_q <= wfull_d;
            wlast_q <= wlast_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rfull_q <= rfull_d;
            rlast_q <= rlast_d;
            rdata_q <= rdata_d;
        end
    end

    assign s_cmd_o   = cmd_q;
    assign s_addr_o  = addr_q;
    assign s_wlast_o = wlast_q;
    assign s_wdata_o = wdata_q;
    assign s_wmask_o = wmask_q;
    assign m_rlast_o = rlast_q;
    assign m_rdata_o = rdata_q;

endmodule

// File: tb/tb_bus_xbar_rr.sv
// Directed bench for bus_xbar_rr: arbitration, DRAM read/write, unmapped faults,
// single-beat slave, forwarded slave error and mid-burst reset.
module tb_bus_xbar_rr;
    localparam int unsigned NM = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned AW = 27;
    localparam logic [NS*AW-1:0] BASE = {27'h4000000, 27'h2000000, 27'h1000000, 27'h0000000};
    localparam logic [NS*AW-1:0] MASK = {27'h6000000, 27'h7000000, 27'h7000000, 27'h7000000};
    localparam logic [AW-1:0] DRAM_A  = 27'h4000040;
    localparam logic [AW-1:0] DRAM_W  = 27'h4000100;
    localparam logic [AW-1:0] MMIO_A  = 27'h2000010;
    localparam logic [AW-1:0] UNMAP_A = 27'h6000000;

    logic              clk_core = 1'b0;
    logic              reset_n;
    logic [NM-1:0]     m_cvalid, m_cready, m_cmd, m_wvalid, m_wready, m_wlast;
    logic [NM-1:0]     m_rvalid, m_rready, m_error, m_eack;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*32-1:0]  m_wdata;
    logic [NM*4-1:0]   m_wmask;
    logic              m_rlast, s_cmd, s_wlast;
    logic [31:0]       m_rdata, s_wdata;
    logic [AW-1:0]     s_addr;
    logic [3:0]        s_wmask;
    logic [NS-1:0]     s_cvalid, s_cready, s_wvalid, s_wready, s_rvalid, s_rready;
    logic [NS-1:0]     s_rlast, s_error, s_eack;
    logic [NS*32-1:0]  s_rdata;

    int vectors = 0;
    int miscompares = 0;

    bus_xbar_rr #(
        .NM(NM), .NS(NS), .AW(AW),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .SLV_NOLAST(4'b0100)
    ) dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .m_cvalid_i(m_cvalid), .m_cready_o(m_cready), .m_cmd_i(m_cmd), .m_addr_i(m_addr),
        .m_wvalid_i(m_wvalid), .m_wready_o(m_wready), .m_wlast_i(m_wlast),
        .m_wdata_i(m_wdata), .m_wmask_i(m_wmask),
        .m_rvalid_o(m_rvalid), .m_rready_i(m_rready), .m_rlast_o(m_rlast), .m_rdata_o(m_rdata),
        .m_error_o(m_error), .m_eack_i(m_eack),
        .s_cmd_o(s_cmd), .s_addr_o(s_addr), .s_wlast_o(s_wlast), .s_wdata_o(s_wdata),
        .s_wmask_o(s_wmask), .s_cvalid_o(s_cvalid), .s_cready_i(s_cready),
        .s_wvalid_o(s_wvalid), .s_wready_i(s_wready), .s_rvalid_i(s_rvalid),
        .s_rready_o(s_rready), .s_rlast_i(s_rlast), .s_rdata_i(s_rdata),
        .s_error_i(s_error), .s_eack_o(s_eack)
    );

    always #5 clk_core = ~clk_core;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        m_cvalid = '0; m_cmd = '0; m_addr = '0; m_wvalid = '0; m_wlast = '0;
        m_wdata = '0; m_wmask = '0; m_rready = '0; m_eack = '0;
        s_cready = '0; s_wready = '0; s_rvalid = '0; s_rlast = '0; s_rdata = '0; s_error = '0;

        // Reset: requests present but nothing granted, registered outputs clear
        m_cvalid = 2'b11;
        tick(); tick();
        #1;
        chk("rst_cready", m_cready, 2'b00);
        chk("rst_scvalid", s_cvalid, 4'b0000);
        chk("rst_merror", m_error, 2'b00);
        chk("rst_saddr", s_addr, 0);
        chk("rst_scmd", s_cmd, 0);
        chk("rst_mrdata", m_rdata, 0);
        chk("rst_rlast_wlast", {m_rlast, s_wlast}, 2'b00);

        // Round robin: both masters read unmapped, eack held high
        m_cmd = 2'b11; m_addr = {UNMAP_A, UNMAP_A}; m_eack = 2'b11;
        reset_n = 1'b1;
        #1;
        chk("rr_first", m_cready, 2'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_cready", m_cready, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_merror", m_error, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        m_cvalid = 2'b10;
        #1;
        chk("rr_single", m_cready, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_single_cready", m_cready, 2'b10);
            chk("rr_single_merror", m_error, 2'b10);
        end
        m_cvalid = 2'b00;
        tick();
        m_eack = 2'b00;
        #1;
        chk("rr_idle_err", m_error, 2'b00);

        // Unmapped read, then a DRAM read accepted in the eack cycle
        m_cvalid = 2'b01;
        #1;
        chk("ur_cready", m_cready, 2'b01);
        tick();
        m_cvalid = 2'b00;
        #1;
        chk("ur_error", m_error, 2'b01);
        chk("ur_nocvalid", s_cvalid, 4'b0000);
        tick();
        chk("ur_error_hold", m_error, 2'b01);
        m_eack = 2'b01; m_cvalid = 2'b01; m_addr[AW-1:0] = DRAM_A; m_rready = 2'b01;
        #1;
        chk("ur_b2b_cready", m_cready, 2'b01);
        tick();
        m_cvalid = 2'b00; m_eack = 2'b00; s_cready = 4'b1000;
        #1;
        chk("rd_err_clear", m_error, 2'b00);
        chk("rd_scvalid", s_cvalid, 4'b1000);
        chk("rd_saddr", s_addr, DRAM_A);
        chk("rd_scmd", s_cmd, 1);
        tick();
        chk("rd_scvalid_done", s_cvalid, 4'b0000);

        // DRAM 4-beat read, streaming
        s_rvalid = 4'b1000; s_rdata[127:96] = 32'hA000_0000; s_rlast = 4'b0000;
        #1;
        chk("rd_srready0", s_rready, 4'b1000);
        for (int b = 1; b < 4; b++) begin
            tick();
            s_rdata[127:96] = 32'hA000_0000 + 32'(b);
            s_rlast = (b == 3) ? 4'b1000 : 4'b0000;
            #1;
            chk("rd_mrvalid", m_rvalid, 2'b01);
            chk("rd_mrdata", m_rdata, 32'hA000_0000 + 32'(b - 1));
            chk("rd_mrlast", m_rlast, 0);
            chk("rd_srready", s_rready, 4'b1000);
        end
        tick();
        s_rvalid = 4'b0000; s_rlast = 4'b0000;
        #1;
        chk("rd_beat4_data", m_rdata, 32'hA000_0003);
        chk("rd_beat4_last", m_rlast, 1);
        chk("rd_beat4_srready", s_rready, 4'b0000);
        tick();
        chk("rd_done", m_rvalid, 2'b00);

        // DRAM 2-beat write from master 1
        m_cmd[1] = 1'b0; m_addr[2*AW-1:AW] = DRAM_W; m_cvalid = 2'b10;
        #1;
        chk("wr_cready", m_cready, 2'b10);
        tick();
        m_cvalid = 2'b00; m_wvalid = 2'b10; m_wdata[63:32] = 32'hBEEF_0001;
        m_wmask[7:4] = 4'hF; m_wlast = 2'b00; s_wready = 4'b1000;
        #1;
        chk("wr_mwready0", m_wready, 2'b10);
        chk("wr_scvalid", s_cvalid, 4'b1000);
        chk("wr_scmd", s_cmd, 0);
        tick();
        m_wdata[63:32] = 32'hBEEF_0002; m_wmask[7:4] = 4'h3; m_wlast = 2'b10;
        #1;
        chk("wr_swvalid1", s_wvalid, 4'b1000);
        chk("wr_sdata1", {s_wdata, s_wmask, s_wlast}, {32'hBEEF_0001, 4'hF, 1'b0});
        chk("wr_mwready1", m_wready, 2'b10);
        tick();
        m_wvalid = 2'b00; m_wlast = 2'b00;
        #1;
        chk("wr_swvalid2", s_wvalid, 4'b1000);
        chk("wr_sdata2", {s_wdata, s_wmask, s_wlast}, {32'hBEEF_0002, 4'h3, 1'b1});
        chk("wr_mwready2", m_wready, 2'b00);
        tick();
        chk("wr_done", s_wvalid, 4'b0000);

        // Unmapped 3-beat write from master 0: absorbed, then error
        m_cmd[0] = 1'b0; m_addr[AW-1:0] = UNMAP_A; m_cvalid = 2'b01;
        #1;
        chk("uw_cready", m_cready, 2'b01);
        tick();
        m_cvalid = 2'b00; m_wvalid = 2'b01; m_wlast = 2'b00;
        #1;
        chk("uw_wready1", m_wready, 2'b01);
        chk("uw_slave_quiet", {s_wvalid, s_cvalid}, 8'h00);
        tick();
        chk("uw_wready2", m_wready, 2'b01);
        tick();
        m_wlast = 2'b01;
        #1;
        chk("uw_wready3", m_wready, 2'b01);
        chk("uw_noerr_yet", m_error, 2'b00);
        tick();
        m_wvalid = 2'b00; m_wlast = 2'b00;
        #1;
        chk("uw_error", m_error, 2'b01);
        chk("uw_slave_quiet2", {s_wvalid, s_cvalid}, 8'h00);
        m_eack = 2'b01;
        tick();
        m_eack = 2'b00;
        #1;
        chk("uw_error_clear", m_error, 2'b00);

        // Single-beat MMIO read: rlast forced
        m_cmd[1] = 1'b1; m_addr[2*AW-1:AW] = MMIO_A; m_cvalid = 2'b10;
        #1;
        chk("nl_cready", m_cready, 2'b10);
        tick();
        m_cvalid = 2'b00; s_cready = 4'b0100; m_rready = 2'b10;
        #1;
        chk("nl_scvalid", s_cvalid, 4'b0100);
        tick();
        s_rvalid = 4'b0100; s_rdata[95:64] = 32'hC0DE_0042; s_rlast = 4'b0000;
        #1;
        chk("nl_srready", s_rready, 4'b0100);
        tick();
        s_rvalid = 4'b0000;
        #1;
        chk("nl_mrvalid", m_rvalid, 2'b10);
        chk("nl_mrdata", m_rdata, 32'hC0DE_0042);
        chk("nl_mrlast", m_rlast, 1);
        tick();
        chk("nl_done", m_rvalid, 2'b00);

        // Slave error coinciding with read data: error wins, data dropped
        m_cmd[0] = 1'b1; m_addr[AW-1:0] = MMIO_A; m_cvalid = 2'b01;
        #1;
        chk("se_cready", m_cready, 2'b01);
        tick();
        m_cvalid = 2'b00; m_rready = 2'b01;
        #1;
        chk("se_scvalid", s_cvalid, 4'b0100);
        tick();
        s_error = 4'b0100; s_rvalid = 4'b0100; s_rdata[95:64] = 32'hDEAD_BEEF;
        #1;
        chk("se_merror", m_error, 2'b01);
        chk("se_srready", s_rready, 4'b0000);
        chk("se_seack0", s_eack, 4'b0000);
        tick();
        chk("se_dropped", m_rvalid, 2'b00);
        chk("se_merror_hold", m_error, 2'b01);
        m_eack = 2'b01;
        #1;
        chk("se_seack", s_eack, 4'b0100);
        tick();
        s_error = 4'b0000; s_rvalid = 4'b0000; m_eack = 2'b00;
        #1;
        chk("se_clear", {m_error, m_rvalid, s_eack}, 8'h00);

        // Reset during a DRAM read burst
        m_cmd[1] = 1'b1; m_addr[2*AW-1:AW] = DRAM_A; m_cvalid = 2'b10;
        s_cready = 4'b1000; m_rready = 2'b00;
        tick();
        m_cvalid = 2'b00;
        tick();
        s_rvalid = 4'b1000; s_rdata[127:96] = 32'h1234_5678;
        tick();
        chk("mr_mrvalid", m_rvalid, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("mr_gated", {m_rvalid, s_rready, s_cvalid}, 10'h000);
        tick();
        reset_n = 1'b1; s_rvalid = 4'b0000;
        #1;
        chk("mr_rdata", m_rdata, 0);
        chk("mr_idle", {m_rvalid, m_error, s_cvalid, s_wvalid}, 12'h000);
        chk("mr_saddr", s_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
